// File: rtl/dot_accumulator_if.sv
// Product-beat stream into the dot-product accumulator and the result port out of it.
// valid/ready: a beat or result transfers on a rising clock edge where valid and ready are both high.
// While the result is valid and not yet taken, the sender holds res_o/res_sat_o/res_cnt_o stable.
interface dot_accumulator_if #(
    parameter int IN_SIZE  = 12,
    parameter int ACC_SIZE = 20,
    parameter int CNT_W    = 8
);
    logic [IN_SIZE-1:0]  prod_i;
    logic                prod_valid_i;
    logic                prod_last_i;
    logic                prod_ready_o;
    logic [ACC_SIZE-1:0] res_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic                res_sat_o;
    logic [CNT_W-1:0]    res_cnt_o;

    modport master (
        output prod_i, prod_valid_i, prod_last_i, res_ready_i,
        input  prod_ready_o, res_o, res_valid_o, res_sat_o, res_cnt_o
    );

    modport slave (
        input  prod_i, prod_valid_i, prod_last_i, res_ready_i,
        output prod_ready_o, res_o, res_valid_o, res_sat_o, res_cnt_o
    );
endinterface

// File: rtl/dot_accumulator.sv
// Saturating dot-product accumulator: sums signed product beats until a last beat,
// then presents the clamped sum, a saturation flag and the beat count on the result port.
module dot_accumulator #(
    parameter int IN_SIZE  = 12,
    parameter int ACC_SIZE = 20,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    dot_accumulator_if.slave bus,
    output logic             dbg_state_o
);
    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_e;

    localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    state_e              state_q, state_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [ACC_SIZE-1:0] res_q, res_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic                res_sat_q, res_sat_d;

    logic [ACC_SIZE:0]   sum;
    logic                ovf;
    logic [ACC_SIZE-1:0] sum_clamped;
    logic [CNT_W-1:0]    cnt_inc;
    logic                accept;

    // One guard bit above the accumulator; the two top bits disagree exactly on overflow.
    always_comb begin
        sum = {acc_q[ACC_SIZE-1], acc_q}
            + {{(ACC_SIZE+1-IN_SIZE){bus.prod_i[IN_SIZE-1]}}, bus.prod_i};
        ovf = sum[ACC_SIZE] ^ sum[ACC_SIZE-1];
        if (!ovf) begin
            sum_clamped = sum[ACC_SIZE-1:0];
        end else if (sum[ACC_SIZE]) begin
            sum_clamped = ACC_MIN;
        end else begin
            sum_clamped = ACC_MAX;
        end
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        accept  = (state_q == ST_ACC) && bus.prod_valid_i;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        res_sat_d = res_sat_q;
        if (clear_i) begin
            // Abort wins over everything, including a beat offered this cycle.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept && bus.prod_last_i) begin
                        res_d     = sum_clamped;
                        res_sat_d = sat_q | ovf;
                        res_cnt_d = cnt_inc;
                        acc_d     = '0;
                        cnt_d     = '0;
                        sat_d     = 1'b0;
                        state_d   = ST_OUT;
                    end else if (accept) begin
                        acc_d = sum_clamped;
                        sat_d = sat_q | ovf;
                        cnt_d = cnt_inc;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready_i) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            res_cnt_q <= '0;
            res_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            res_sat_q <= res_sat_d;
        end
    end

    // Handshake outputs are pure decodes of the state flop.
    assign bus.prod_ready_o = (state_q == ST_ACC);
    assign bus.res_valid_o  = (state_q == ST_OUT);
    assign bus.res_o        = res_q;
    assign bus.res_sat_o    = res_sat_q;
    assign bus.res_cnt_o    = res_cnt_q;
    assign dbg_state_o      = (state_q == ST_OUT);
endmodule
